// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for multdiv_seq (divider gated by MULTDIV_DIV_EN)
package multdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam int unsigned MUL_STEPS = 16;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic [31:0]      INT_MIN  = 32'h8000_0000;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);

    // Magnitude of a two's complement word; |INT_MIN| stays 0x80000000 as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_seq_booth_step.sv
// rtl/multdiv_seq_booth_step.sv - one radix-4 Booth digit: recode, 34-bit add, 2-bit arithmetic shift
module booth_step (
    input  logic [65:0] prod_i,
    input  logic        guard_i,
    input  logic [31:0] mcand_i,
    output logic [65:0] prod_o,
    output logic        guard_o
);

    logic [33:0] a_ext;
    logic [33:0] pp;
    logic [33:0] sum;

    assign a_ext = {{2{mcand_i[31]}}, mcand_i};

    // Pick the partial product from {b[i+1], b[i], b[i-1]}, add it to the upper accumulator and shift by two.
    always_comb begin
        pp = '0;
        unique case ({prod_i[1:0], guard_i})
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        sum     = prod_i[65:32] + pp;
        prod_o  = {{2{sum[33]}}, sum, prod_i[31:2]};
        guard_o = prod_i[1];
    end

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - iterative signed 32-bit multiply/divide; divider compiled in only with MULTDIV_DIV_EN
module multdiv_seq
    import multdiv_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t             state_q;
    logic [CNT_W-1:0]   step_q;
    logic [31:0]        result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    // Booth multiplier state: {accumulator[33:0], multiplier[31:0]} plus the implicit b[-1] bit.
    logic [31:0]        mcand_q;
    logic [65:0]        prod_q;
    logic               guard_q;
    logic [65:0]        prod_nx;
    logic               guard_nx;
    logic               mul_ovf;

    booth_step u_booth (
        .prod_i  (prod_q),
        .guard_i (guard_q),
        .mcand_i (mcand_q),
        .prod_o  (prod_nx),
        .guard_o (guard_nx)
    );

    // The low word is a valid signed result only if bits [63:31] are a pure sign extension.
    assign mul_ovf = ~((&prod_nx[63:31]) | ~(|prod_nx[63:31]));

`ifdef MULTDIV_DIV_EN
    // Non-restoring divider on magnitudes; the remainder keeps two guard bits so 2*rem never wraps.
    logic [33:0]        rem_q;
    logic [31:0]        quo_q;
    logic [31:0]        dvs_q;
    logic               neg_q;
    logic               dz_q;
    logic [33:0]        rem_sh;
    logic [33:0]        rem_nx;
    logic [31:0]        quo_nx;
    logic [31:0]        quo_signed;
    logic               quo_ovf;

    // One divide step: add or subtract the divisor depending on the remainder sign, quotient bit from the new sign.
    always_comb begin
        rem_sh     = {rem_q[32:0], quo_q[31]};
        rem_nx     = rem_q[33] ? (rem_sh + {2'b00, dvs_q}) : (rem_sh - {2'b00, dvs_q});
        quo_nx     = {quo_q[30:0], ~rem_nx[33]};
        quo_signed = neg_q ? (~quo_q + 32'd1) : quo_q;
        // A positive quotient of 2^31 only arises from INT_MIN / -1.
        quo_ovf    = ~neg_q & quo_q[31];
    end
`endif

    // Control FSM with registered outputs and all datapath register updates.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            guard_q  <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    step_q  <= '0;
                    if (ctrl_MULT) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                        mcand_q <= data_operandA;
                        prod_q  <= {34'd0, data_operandB};
                        guard_q <= 1'b0;
                    end else if (ctrl_DIV) begin
                        busy_q  <= 1'b1;
`ifdef MULTDIV_DIV_EN
                        neg_q   <= data_operandA[31] ^ data_operandB[31];
                        rem_q   <= '0;
                        quo_q   <= abs32(data_operandA);
                        dvs_q   <= abs32(data_operandB);
                        dz_q    <= (data_operandB == 32'd0);
                        // A zero divisor skips the iteration and completes through FIX.
                        state_q <= (data_operandB == 32'd0) ? ST_FIX : ST_DIV;
`else
                        // Without a divider every divide completes as an illegal operation.
                        state_q <= ST_FIX;
`endif
                    end
                end

                ST_MUL: begin
                    prod_q  <= prod_nx;
                    guard_q <= guard_nx;
                    step_q  <= step_q + CNT_W'(1);
                    if (step_q == MUL_LAST) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= prod_nx[31:0];
                        exc_q    <= mul_ovf;
                    end
                end

`ifdef MULTDIV_DIV_EN
                ST_DIV: begin
                    rem_q  <= rem_nx;
                    quo_q  <= quo_nx;
                    step_q <= step_q + CNT_W'(1);
                    if (step_q == DIV_LAST) begin
                        state_q <= ST_FIX;
                    end
                end
`endif

                ST_FIX: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
`ifdef MULTDIV_DIV_EN
                    if (dz_q) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end else begin
                        result_q <= quo_signed;
                        exc_q    <= quo_ovf;
                    end
`else
                    result_q <= '0;
                    exc_q    <= 1'b1;
`endif
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - self-checking bench for multdiv_seq (follows MULTDIV_DIV_EN when defined)
module tb_multdiv_seq;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mult;
    logic        div;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    multdiv_seq dut (
        .clk            (clk),
        .clr            (clr),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (mult),
        .ctrl_DIV       (div),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic        d;
        logic [31:0] er;
        logic        ee;
        int          el;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d,
                         output logic [31:0] r, output logic e, output int lat);
        longint p;
        r = '0; e = 1'b0; lat = 0;
        if (m) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p != longint'($signed(r)));
            lat = 16;
        end else if (d) begin
            if (!DIV_EN || b == 32'd0) begin
                r = '0; e = 1'b1; lat = 1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = a; e = 1'b1; lat = 33;
            end else begin
                r = $signed(a) / $signed(b); e = 1'b0; lat = 33;
            end
        end
    endtask

    // Called at a falling edge: present a start, let the next rising edge capture it, then drop it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        opa = a; opb = b; mult = m; div = d;
        @(posedge clk);
        #1;
        mult = 1'b0; div = 1'b0;
        opa = $urandom; opb = $urandom;
    endtask

    // Count edges after capture until data_resultRDY; optionally pulse ctrl_DIV at edge inj.
    task automatic wait_done(input int inj, output int lat, output logic [31:0] res,
                             output logic e, output logic busy_ok);
        busy_ok = 1'b1; lat = 0; res = '0; e = 1'b0;
        @(negedge clk);
        if (!busy) busy_ok = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rdy) begin
                lat = k; res = result; e = exc;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (inj != 0 && k == inj - 1) div = 1'b1;
            if (inj != 0 && k == inj) div = 1'b0;
        end
    endtask

    task automatic do_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d, input logic [31:0] er, input logic ee, input int el);
        int          lat;
        logic [31:0] res;
        logic        e;
        logic        bok;
        @(negedge clk);
        start_op(a, b, m, d);
        wait_done(0, lat, res, e, bok);
        chk({name, " result"}, res, er);
        chk({name, " exception"}, 32'(e), 32'(ee));
        chk({name, " latency"}, 32'(lat), 32'(el));
        if (el > 1) chk({name, " busy"}, 32'(bok), 32'd1);
        @(negedge clk);
        chk({name, " rdy once"}, 32'(rdy), 32'd0);
        chk({name, " hold"}, result, er);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        e;
        logic        bok;
        logic [31:0] ra, rb, er;
        logic        rm, rd, ee;
        int          el;

        vt[0]  = '{32'd7,          32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b0, 16};
        vt[1]  = '{32'h0001_0000,  32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 16};
        vt[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 16};
        vt[3]  = '{32'd6,          32'd3,         1'b1, 1'b1, 32'd18,        1'b0, 16};
        vt[4]  = '{32'h8000_0000,  32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 16};
        vt[5]  = '{32'h8000_0000,  32'd1,         1'b1, 1'b0, 32'h8000_0000, 1'b0, 16};
        vt[6]  = '{32'd5,          32'd0,         1'b0, 1'b1, 32'd0,         1'b1, 1};
        vt[7]  = '{32'hFFFF_FFF9,  32'd2,         1'b0, 1'b1, DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN, DIV_EN ? 33 : 1};
        vt[8]  = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b1, DIV_EN ? 32'h8000_0000 : 32'd0, 1'b1, DIV_EN ? 33 : 1};
        vt[9]  = '{32'd6,          32'd3,         1'b0, 1'b1, DIV_EN ? 32'd2 : 32'd0,         !DIV_EN, DIV_EN ? 33 : 1};
        vt[10] = '{32'h8000_0000,  32'd1,         1'b0, 1'b1, DIV_EN ? 32'h8000_0000 : 32'd0, !DIV_EN, DIV_EN ? 33 : 1};
        vt[11] = '{32'd7,          32'hFFFF_FFF9, 1'b0, 1'b1, DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, DIV_EN ? 33 : 1};

        clr = 1'b1; opa = '0; opb = '0; mult = 1'b0; div = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset result", result, 32'd0);
        chk("reset exception", 32'(exc), 32'd0);
        chk("reset rdy", 32'(rdy), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].m, vt[i].d, vt[i].er, vt[i].ee, vt[i].el);
        end

        // ctrl_DIV arriving mid-multiply is ignored.
        @(negedge clk);
        start_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        wait_done(5, lat, res, e, bok);
        chk("ignored div result", res, 32'hFFFF_FFEB);
        chk("ignored div exception", 32'(e), 32'd0);
        chk("ignored div latency", 32'(lat), 32'd16);

        // Back-to-back: a start presented during DONE is taken without an idle cycle.
        @(negedge clk);
        start_op(32'd2, 32'd3, 1'b1, 1'b0);
        wait_done(0, lat, res, e, bok);
        chk("chain first result", res, 32'd6);
        chk("chain first latency", 32'(lat), 32'd16);
        start_op(32'd4, 32'd5, 1'b1, 1'b0);
        wait_done(0, lat, res, e, bok);
        chk("chain second result", res, 32'd20);
        chk("chain second latency", 32'(lat), 32'd16);
        chk("chain second busy", 32'(bok), 32'd1);

        // Asynchronous clear in the middle of a multiply.
        @(negedge clk);
        start_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr result", result, 32'd0);
        chk("clr exception", 32'(exc), 32'd0);
        chk("clr rdy", 32'(rdy), 32'd0);
        chk("clr busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        do_vec("after clr", 32'd2, 32'd3, 1'b1, 1'b0, 32'd6, 1'b0, 16);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 7)) - 32'd3;
                1: ra = 32'($urandom_range(0, 2000)) - 32'd1000;
                2: begin ra = ra >>> 12; rb = rb >>> 14; end
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: begin rm = 1'b1; rd = 1'b0; end
                1: begin rm = 1'b0; rd = 1'b1; end
                default: begin rm = 1'b1; rd = 1'b1; end
            endcase
            model(ra, rb, rm, rd, er, ee, el);
            do_vec($sformatf("rand%0d", i), ra, rb, rm, rd, er, ee, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative signed 32-bit multiply/divide unit inside the execute stage, directly upstream of the X/M pipeline latch. It accepts a one-cycle start pulse from decode and runs a multi-cycle operation while holding the pipeline stalled. It then presents the result and exception flag for one cycle, so the execute stage can write them into the X/M latch's data and exception fields.

## Interface
Parameters: none; step counts are fixed constants (see Structure).
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- data_operandA  input  32  multiplicand / dividend (two's complement)
- data_operandB  input  32  multiplier / divisor (two's complement)
- ctrl_MULT  input  1  start-multiply pulse
- ctrl_DIV  input  1  start-divide pulse
- data_result  output  32  low 32 bits of product, or quotient
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_result
- data_resultRDY  output  1  one-cycle pulse: result and exception valid
- busy  output  1  stall request to the pipeline

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Start:
  - A start is sampled at a rising edge while in IDLE or DONE.
  - Operands are captured at that same edge; the unit does not require them held afterward.
  - If ctrl_MULT and ctrl_DIV are both high, MULT wins.
  - Starts in MUL, DIV or FIX are ignored.
- MUL:
  - Radix-4 Booth, one recoded digit per cycle, 16 steps, 66-bit product/multiplier register.
  - Goes to DONE after step 16.
  - Exception = 1 when the 64-bit product does not fit in 32 signed bits (bits [63:31] not all equal).
- DIV:
  - Non-restoring division on operand magnitudes, 32 steps.
  - FIX applies the quotient sign (negative iff operand signs differ), truncating toward zero.
  - The remainder is discarded.
- Divide by zero:
  - Detected at capture; DIV is skipped and the unit goes to DONE on the next edge.
  - Result 0, exception 1.
- Quotient overflow: 0x80000000 / -1 gives result 0x80000000, exception 1.
- DONE:
  - data_resultRDY = 1 for exactly this cycle.
  - Next edge goes to IDLE, or to MUL/DIV if a start is present (back-to-back).
- data_result and data_exception hold their last values until the next completion or reset.
- busy = 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- clr at any time, including mid-operation: state IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, step counter = 0.

## Timing
- Edge 0 is the capture edge. busy is high from immediately after edge 0.
- MUL: steps at edges 1–16; DONE entered at edge 16; data_resultRDY high between edges 16 and 17.
- DIV: steps at edges 1–32; FIX at edge 33; DONE entered at edge 33; data_resultRDY high between edges 33 and 34.
- Divide by zero: DONE entered at edge 1.
- Outputs are registered; no combinational path from inputs to outputs.
- A start sampled in DONE re-enters MUL/DIV at that edge. busy rises immediately after it, with no idle gap.

## Configuration
- MULTDIV_DIV_EN defined:
  - Full divide datapath (DIV, FIX states, divisor register) is compiled in.
- MULTDIV_DIV_EN undefined:
  - Divide datapath is removed.
  - ctrl_DIV still starts an operation and goes to DONE on the next edge with result 0, exception 1 (illegal-op signalling).
  - MUL behaviour is unchanged.

## Structure
- Package multdiv_pkg holds:
  - state enum (IDLE, MUL, DIV, FIX, DONE)
  - MUL_STEPS = 16, DIV_STEPS = 32
  - INT_MIN = 32'h80000000
  - 6-bit step-counter width
- One sub-module, booth_step: combinational radix-4 recode of 3 multiplier bits into {0, ±A, ±2A} plus the 34-bit add and 2-bit arithmetic shift. Instantiated once.
- The FSM, counter, registers and division datapath live in multdiv_seq.

## Test plan
- MULT 7 × -3: data_result = 0xFFFFFFEB (-21), exception 0; RDY pulses exactly once at cycle 16 after capture; busy high cycles 1–15.
- MULT 0x00010000 × 0x00010000: result 0x00000000, exception 1. MULT 0xFFFFFFFF × 0xFFFFFFFF: result 1, exception 0.
- DIV -7 / 2: result 0xFFFFFFFD (-3), exception 0; RDY at cycle 33. DIV 0x80000000 / -1: result 0x80000000, exception 1.
- DIV 5 / 0: RDY at cycle 1, result 0, exception 1. With MULTDIV_DIV_EN undefined, DIV 6 / 3 gives the same response.
- Ignored and coincident starts:
  - ctrl_DIV pulsed at cycle 5 of a MULT: ignored; MULT result unaffected.
  - ctrl_MULT and ctrl_DIV together on 6 and 3: product 18 returned.
  - Start asserted in DONE: busy rises the next cycle; the new result arrives on schedule.
- clr asserted at MUL step 8 (asynchronously, mid-cycle): all outputs 0 immediately. A following MULT 2 × 3 returns 6.
